// File: rtl/snn_ctrl_pkg.sv
// rtl/snn_ctrl_pkg.sv - shared state encoding and ctrl/status bit map for the SNN run scheduler
package snn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STEP   = 3'd2,
    WAIT   = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;
  localparam int CTRL_BUSY_BIT  = 2;
  localparam int CTRL_DONE_BIT  = 3;
  localparam int ERROR_BIT      = 4;

  // Packs the scheduler flags into their status readback positions.
  function automatic logic [4:0] status_bits(input logic busy, input logic done, input logic error);
    logic [4:0] w_s;
    w_s = '0;
    w_s[CTRL_BUSY_BIT] = busy;
    w_s[CTRL_DONE_BIT] = done;
    w_s[ERROR_BIT]     = error;
    return w_s;
  endfunction

endpackage

// File: rtl/snn_step_watchdog.sv
// rtl/snn_step_watchdog.sv - per-timestep watchdog counter; expires after STEP_TIMEOUT enabled cycles
module snn_step_watchdog
  import snn_ctrl_pkg::*;
#(
  parameter int STEP_TIMEOUT = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int WD_W = $clog2(STEP_TIMEOUT);

  logic [WD_W-1:0] r_cnt;

  assign o_expire = i_en && (r_cnt == WD_W'(STEP_TIMEOUT - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + WD_W'(1);
    end
  end

endmodule

// File: rtl/snn_run_scheduler.sv
// rtl/snn_run_scheduler.sv - sequences one inference run: clear, sim_time timesteps, sticky done/error
module snn_run_scheduler
  import snn_ctrl_pkg::*;
#(
  parameter int CLR_CYCLES   = 4,
  parameter int STEP_TIMEOUT = 1024,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 Local_Reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] sim_time,
  input  logic                 step_done,
  output logic                 step_start,
  output logic                 neuron_clr,
  output logic                 counter_clr,
  output logic                 network_busy,
  output logic                 done,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] timestep_count
);

  localparam int CLR_W = $clog2(CLR_CYCLES + 1);

  state_t               r_state;
  logic [CLR_W-1:0]     r_clr_cnt;
  logic [CNT_WIDTH-1:0] r_sim_lat;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_step_done;
  logic                 r_step_start;
  logic                 r_clr;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;
  logic                 w_expire;
  logic [CNT_WIDTH-1:0] w_count_next;

  assign w_count_next = r_count + CNT_WIDTH'(1);

  snn_step_watchdog #(
    .STEP_TIMEOUT(STEP_TIMEOUT)
  ) u_watchdog (
    .i_clk   (S_AXI_ACLK),
    .i_rst   (Local_Reset),
    .i_clr   (r_state == STEP),
    .i_en    (r_state == WAIT),
    .o_expire(w_expire)
  );

  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) begin
      r_state      <= IDLE;
      r_clr_cnt    <= '0;
      r_sim_lat    <= '0;
      r_count      <= '0;
      r_step_done  <= 1'b0;
      r_step_start <= 1'b0;
      r_clr        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      // Only completions seen while waiting count; this also drops one that lands with step_start.
      r_step_done  <= step_done && (r_state == WAIT);
      r_step_start <= 1'b0;
      r_clr        <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !abort) begin
            r_state   <= CLEAR;
            r_sim_lat <= sim_time;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_clr_cnt <= '0;
            r_clr     <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        CLEAR, STEP, WAIT: begin
          if (abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_clr   <= 1'b1;
          end else if (r_state == CLEAR) begin
            if (r_clr_cnt == CLR_W'(CLR_CYCLES - 1)) begin
              if (r_sim_lat == '0) begin
                r_state <= FINISH;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state      <= STEP;
                r_step_start <= 1'b1;
              end
            end else begin
              r_clr_cnt <= r_clr_cnt + CLR_W'(1);
              r_clr     <= 1'b1;
            end
          end else if (r_state == STEP) begin
            r_state <= WAIT;
          end else if (r_step_done) begin
            r_count <= w_count_next;
            if (w_count_next == r_sim_lat) begin
              r_state <= FINISH;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state      <= STEP;
              r_step_start <= 1'b1;
            end
          end else if (w_expire) begin
            r_state <= FINISH;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_error <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign step_start     = r_step_start;
  assign neuron_clr     = r_clr;
  assign counter_clr    = r_clr;
  assign network_busy   = r_busy;
  assign done           = r_done;
  assign error          = r_error;
  assign timestep_count = r_count;

endmodule

// File: tb/tb_snn_run_scheduler.sv
// tb/tb_snn_run_scheduler.sv - scoreboard bench for snn_run_scheduler
module tb_snn_run_scheduler;

  localparam int CW = 32;
  localparam int EV_STEP = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int kind;
    int cyc;
    int count;
    int err;
  } ev_t;

  logic          S_AXI_ACLK = 1'b0;
  logic          Local_Reset;
  logic          start;
  logic          abort;
  logic [CW-1:0] sim_time;
  logic          step_done;
  logic          step_start;
  logic          neuron_clr;
  logic          counter_clr;
  logic          network_busy;
  logic          done;
  logic          error;
  logic [CW-1:0] timestep_count;

  int  cyc = 0;
  int  n_pass = 0;
  int  n_total = 0;
  int  resp_delay = 0;
  int  req_cnt = 0;
  ev_t exp_q[$];

  snn_run_scheduler #(
    .CLR_CYCLES  (4),
    .STEP_TIMEOUT(16),
    .CNT_WIDTH   (CW)
  ) dut (
    .S_AXI_ACLK    (S_AXI_ACLK),
    .Local_Reset   (Local_Reset),
    .start         (start),
    .abort         (abort),
    .sim_time      (sim_time),
    .step_done     (step_done),
    .step_start    (step_start),
    .neuron_clr    (neuron_clr),
    .counter_clr   (counter_clr),
    .network_busy  (network_busy),
    .done          (done),
    .error         (error),
    .timestep_count(timestep_count)
  );

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;
  always @(posedge S_AXI_ACLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Network model: answers each step_start with a one-cycle step_done resp_delay cycles later.
  initial begin
    int pend;
    int seen;
    pend = 0;
    seen = 0;
    step_done = 1'b0;
    forever begin
      @(negedge S_AXI_ACLK);
      step_done = 1'b0;
      if (req_cnt != seen) begin
        seen = req_cnt;
        step_done = 1'b1;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) step_done = 1'b1;
      end
      if (step_start && resp_delay > 0) pend = resp_delay;
    end
  end

  initial begin
    logic prev_done;
    logic prev_busy;
    ev_t  e;
    prev_done = 1'b0;
    prev_busy = 1'b0;
    forever begin
      @(negedge S_AXI_ACLK);
      if (step_start) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_step_start: got pulse at cycle %0d, expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          check("step_kind", EV_STEP, e.kind);
          check("step_cycle", cyc, e.cyc);
        end
      end
      if (done && !prev_done) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: got rise at cycle %0d, expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          check("done_kind", EV_DONE, e.kind);
          check("done_cycle", cyc, e.cyc);
          check("done_count", timestep_count, e.count);
          check("done_error", error, e.err);
          check("done_busy", network_busy, 0);
          check("busy_before_done", prev_busy, 1);
        end
      end
      prev_done = done;
      prev_busy = network_busy;
    end
  end

  function automatic ev_t mk(input int kind, input int c, input int count, input int err);
    ev_t e;
    e.kind  = kind;
    e.cyc   = c;
    e.count = count;
    e.err   = err;
    return e;
  endfunction

  // With 4 clear cycles and a 5-cycle network: steps at t0+5, t0+12, ... ; done at t0+5+7n.
  task automatic push_run(input int t0, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(mk(EV_STEP, t0 + 5 + 7 * k, 0, 0));
    exp_q.push_back(mk(EV_DONE, t0 + 5 + 7 * n, n, 0));
  endtask

  task automatic do_start(input logic [CW-1:0] st, output int t0);
    @(negedge S_AXI_ACLK);
    sim_time = st;
    start = 1'b1;
    t0 = cyc;
    @(negedge S_AXI_ACLK);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge S_AXI_ACLK);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge S_AXI_ACLK);
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int t0;
    int t1;
    Local_Reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    sim_time = '0;
    repeat (2) @(negedge S_AXI_ACLK);
    check("rst_busy", network_busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_step_start", step_start, 0);
    check("rst_clr", {neuron_clr, counter_clr}, 0);
    check("rst_count", timestep_count, 0);
    Local_Reset = 1'b0;
    repeat (2) @(negedge S_AXI_ACLK);

    // 1: three timesteps
    resp_delay = 5;
    do_start(3, t0);
    push_run(t0, 3);
    drain("t1_drain", 60);
    check("t1_count", timestep_count, 3);
    check("t1_done", done, 1);
    check("t1_error", error, 0);

    // 2: zero timesteps, clear phase only
    do_start(0, t0);
    exp_q.push_back(mk(EV_DONE, t0 + 5, 0, 0));
    for (int i = 1; i <= 4; i++) begin
      check("t2_clr_phase", {neuron_clr, counter_clr, network_busy}, 3'b111);
      @(negedge S_AXI_ACLK);
    end
    check("t2_clr_end", {neuron_clr, counter_clr}, 0);
    drain("t2_drain", 10);
    check("t2_count", timestep_count, 0);

    // 3: restart with new sim_time during the run is ignored
    do_start(10, t0);
    push_run(t0, 10);
    wait_cyc(t0 + 15);
    sim_time = 2;
    start = 1'b1;
    @(negedge S_AXI_ACLK);
    start = 1'b0;
    drain("t3_drain", 120);
    check("t3_count", timestep_count, 10);

    // 4: network never answers; 16 wait cycles then abort with error
    resp_delay = 0;
    do_start(5, t0);
    exp_q.push_back(mk(EV_STEP, t0 + 5, 0, 0));
    exp_q.push_back(mk(EV_DONE, t0 + 22, 0, 1));
    drain("t4_drain", 60);
    check("t4_error", error, 1);
    check("t4_busy", network_busy, 0);

    // 5: abort in WAIT after three completed steps, then a full rerun
    resp_delay = 5;
    do_start(8, t0);
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(EV_STEP, t0 + 5 + 7 * k, 0, 0));
    wait_cyc(t0 + 28);
    abort = 1'b1;
    @(negedge S_AXI_ACLK);
    abort = 1'b0;
    check("t5_abort_busy", network_busy, 0);
    check("t5_abort_clr", {neuron_clr, counter_clr}, 2'b11);
    check("t5_abort_step", step_start, 0);
    check("t5_abort_done", done, 0);
    check("t5_abort_count", timestep_count, 3);
    @(negedge S_AXI_ACLK);
    check("t5_clr_one_cycle", {neuron_clr, counter_clr}, 0);
    wait_cyc(t0 + 40);
    check("t5_count_held", timestep_count, 3);
    drain("t5_partial_drain", 2);
    do_start(8, t1);
    push_run(t1, 8);
    drain("t5_rerun_drain", 100);
    check("t5_rerun_count", timestep_count, 8);

    // 6: asynchronous reset mid-WAIT with a step_done pulse during reset
    resp_delay = 0;
    do_start(4, t0);
    exp_q.push_back(mk(EV_STEP, t0 + 5, 0, 0));
    wait_cyc(t0 + 7);
    #2;
    Local_Reset = 1'b1;
    #1;
    check("t6_async_busy", network_busy, 0);
    check("t6_async_outs", {step_start, neuron_clr, counter_clr, done, error}, 0);
    check("t6_async_count", timestep_count, 0);
    req_cnt++;
    repeat (3) @(negedge S_AXI_ACLK);
    Local_Reset = 1'b0;
    repeat (20) @(negedge S_AXI_ACLK);
    check("t6_idle_busy", network_busy, 0);
    check("t6_idle_count", timestep_count, 0);
    check("t6_idle_done", done, 0);
    drain("t6_drain", 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
